// File: rtl/regfile_pkg.sv
// Shared register-file defines: bus types, sizes and control-level encodings.
package regfile_pkg;
  localparam int RegNum     = 32;
  localparam int RegNumLog2 = 5;
  localparam int RegWidth   = 32;

  typedef logic [RegWidth-1:0]   RegBus;
  typedef logic [RegNumLog2-1:0] RegAddrBus;

  localparam RegBus     ZeroWord   = '0;
  localparam RegAddrBus NOPRegAddr = 5'b00000;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;
  localparam logic RstEnable    = 1'b0;
  localparam logic RstDisable   = 1'b1;
endpackage

// File: rtl/regfile_if.sv
// Write-back commit and decode read bus between the pipeline and the register file.
interface regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2
  );
  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2,
    output rdata1, rdata2
  );
endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port: reset/enable/r0 gating, then write-first bypass.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [DATA_W-1:0] rdata
);
  always_comb begin
    rdata = '0;
    if (rst == RstEnable)                         rdata = '0;
    else if (re == ReadDisable)                   rdata = '0;
    else if (raddr == ADDR_W'(NOPRegAddr))        rdata = '0;
    else if (we == WriteEnable && raddr == waddr) rdata = wdata;
    else                                          rdata = rword;
  end
endmodule

// File: rtl/regfile.sv
// General-purpose register file: one write-back port, two bypassed read ports.
module regfile
  import regfile_pkg::*;
#(
  parameter int REG_NUM = RegNum,
  parameter int DATA_W  = RegWidth,
  parameter int ADDR_W  = RegNumLog2
) (
  input logic      clk,
  input logic      rst,
  regfile_if.slave bus
);
  localparam int NUM_RD = 2;

  logic [REG_NUM-1:0][DATA_W-1:0] regs;

  // r0 is only ever cleared; the waddr check keeps writes away from it.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) regs <= '0;
    else if (bus.we == WriteEnable && bus.waddr != ADDR_W'(NOPRegAddr))
      regs[bus.waddr] <= bus.wdata;
  end

  logic [NUM_RD-1:0]             re_v;
  logic [NUM_RD-1:0][ADDR_W-1:0] raddr_v;
  logic [NUM_RD-1:0][DATA_W-1:0] rdata_v;

  assign re_v    = {bus.re2, bus.re1};
  assign raddr_v = {bus.raddr2, bus.raddr1};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd (
      .rst   (rst),
      .re    (re_v[p]),
      .raddr (raddr_v[p]),
      .we    (bus.we),
      .waddr (bus.waddr),
      .wdata (bus.wdata),
      .rword (regs[raddr_v[p]]),
      .rdata (rdata_v[p])
    );
  end

  assign bus.rdata1 = rdata_v[0];
  assign bus.rdata2 = rdata_v[1];
endmodule

// File: tb/tb_regfile.sv
// Directed plus randomized checks of regfile against an array-based reference.
module tb_regfile;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] mdl [32];

  always #5 clk = ~clk;

  regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile #(.REG_NUM(32), .DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic re, input logic [4:0] ra);
    if (!rst || !re || ra == 5'd0) return 32'h0;
    if (bus.we && ra == bus.waddr) return bus.wdata;
    return mdl[ra];
  endfunction

  // Commit the current inputs into the reference, then advance past the edge.
  task automatic tick();
    if (!rst) foreach (mdl[i]) mdl[i] = 32'h0;
    else if (bus.we && bus.waddr != 5'd0) mdl[bus.waddr] = bus.wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
    tick();
    bus.we = 1'b0;
  endtask

  function automatic logic [4:0] rnd_addr();
    logic [4:0] a;
    a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    return a;
  endfunction

  initial begin
    foreach (mdl[i]) mdl[i] = 32'h0;
    bus.we = 0; bus.waddr = 0; bus.wdata = 0;
    bus.re1 = 0; bus.raddr1 = 0; bus.re2 = 0; bus.raddr2 = 0;
    rst = 1'b0;
    tick(); tick();
    bus.re1 = 1; bus.raddr1 = 5'd3;
    #1 chk("reset_hold_out", bus.rdata1, 32'h0);
    rst = 1'b1;
    #1 chk("reset_state_r3", bus.rdata1, 32'h0);

    // 1: reset clears stored data
    wr(5'd5, 32'hDEADBEEF);
    bus.re1 = 1; bus.raddr1 = 5'd5;
    #1 chk("r5_written", bus.rdata1, 32'hDEADBEEF);
    rst = 1'b0;
    #1 chk("rst_low_out", bus.rdata1, 32'h0);
    tick();
    rst = 1'b1;
    #1 chk("r5_after_reset", bus.rdata1, 32'h0);

    // 2: basic write then dual read
    wr(5'd7, 32'h12345678);
    bus.re1 = 1; bus.raddr1 = 5'd7; bus.re2 = 1; bus.raddr2 = 5'd7;
    #1 chk("rd1_r7", bus.rdata1, 32'h12345678);
    chk("rd2_r7", bus.rdata2, 32'h12345678);

    // 3: r0 is hardwired
    bus.we = 1; bus.waddr = 5'd0; bus.wdata = 32'hFFFFFFFF;
    bus.raddr1 = 5'd0;
    #1 chk("r0_no_bypass", bus.rdata1, 32'h0);
    tick();
    bus.we = 0;
    #1 chk("r0_after_write", bus.rdata1, 32'h0);

    // 4: same-cycle bypass, other port unaffected
    wr(5'd3, 32'h11111111);
    wr(5'd4, 32'hA5A5A5A5);
    bus.we = 1; bus.waddr = 5'd3; bus.wdata = 32'h22222222;
    bus.re1 = 1; bus.raddr1 = 5'd3; bus.re2 = 1; bus.raddr2 = 5'd4;
    #1 chk("bypass_rd1", bus.rdata1, 32'h22222222);
    chk("bypass_rd2_r4", bus.rdata2, 32'hA5A5A5A5);
    tick();
    bus.we = 0;
    #1 chk("r3_committed", bus.rdata1, 32'h22222222);

    // 5: read enable gating, also against a bypass hit
    wr(5'd9, 32'hCAFEF00D);
    bus.re2 = 0; bus.raddr2 = 5'd9;
    #1 chk("re2_off", bus.rdata2, 32'h0);
    bus.we = 1; bus.waddr = 5'd9; bus.wdata = 32'h01020304;
    #1 chk("re2_off_bypass", bus.rdata2, 32'h0);
    bus.re2 = 1;
    #1 chk("re2_on_bypass", bus.rdata2, 32'h01020304);
    bus.we = 0;

    // 6: reset swallows an in-flight write and its bypass
    rst = 1'b0;
    bus.we = 1; bus.waddr = 5'd10; bus.wdata = 32'h55AA55AA;
    bus.re1 = 1; bus.raddr1 = 5'd10;
    #1 chk("rst_bypass_off", bus.rdata1, 32'h0);
    tick();
    rst = 1'b1; bus.we = 0;
    #1 chk("r10_dropped", bus.rdata1, 32'h0);
    bus.raddr2 = 5'd9;
    #1 chk("r9_cleared", bus.rdata2, 32'h0);

    // Randomized traffic against the reference array
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 31) != 0);
      bus.we    = ($urandom_range(0, 3) != 0);
      bus.waddr = rnd_addr();
      bus.wdata = $urandom();
      bus.re1   = ($urandom_range(0, 7) != 0);
      bus.raddr1 = ($urandom_range(0, 3) == 0) ? bus.waddr : rnd_addr();
      bus.re2   = ($urandom_range(0, 7) != 0);
      bus.raddr2 = ($urandom_range(0, 3) == 0) ? bus.raddr1 : rnd_addr();
      #1;
      chk("rand_rd1", bus.rdata1, ref_rd(bus.re1, bus.raddr1));
      chk("rand_rd2", bus.rdata2, ref_rd(bus.re2, bus.raddr2));
      tick();
    end

    // Sweep all registers after the random phase with writes idle
    rst = 1'b1; bus.we = 0; bus.re1 = 1; bus.re2 = 1;
    for (int a = 0; a < 32; a++) begin
      bus.raddr1 = 5'(a);
      bus.raddr2 = 5'(31 - a);
      #1;
      chk("sweep_rd1", bus.rdata1, ref_rd(1'b1, 5'(a)));
      chk("sweep_rd2", bus.rdata2, ref_rd(1'b1, 5'(31 - a)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
